gf163_operand_loader: RTL and testbench
=======================================

// Module: gf163_operand_loader
// PURPOSE
//  Word-serial operand loader that drives the 163-bit GF(2^163) adder's operand interface.
//  It accepts 32-bit words from the processor data path and assembles operand A, then operand B.
//  It presents both operands on adder_in1/adder_in2 with a valid/ready handshake.
//  The pair is held stable until the downstream consumer of adder_out accepts it.
// PARAMETERS
//  FIELD_W  163  field element width in bits (adder_in1/adder_in2 width)
//  BUS_W    32   input word width
//  NWORDS   6    words per operand, = ceil(FIELD_W/BUS_W); derived, do not override
// PORTS
//  clk        in   1        single clock, all logic on rising edge
//  rst_n      in   1        synchronous reset, active-low
//  s_data     in   BUS_W    input word; least-significant word of an operand first
//  s_valid    in   1        s_data valid
//  s_ready    out  1        loader accepts a word this cycle
//  abort      in   1        synchronous flush of any partial or pending load
//  adder_in1  out  FIELD_W  operand A to adder
//  adder_in2  out  FIELD_W  operand B to adder
//  op_valid   out  1        operand pair complete and stable
//  op_ready   in   1        consumer takes the pair this cycle
//  pad_err    out  1        one-cycle pulse: nonzero pad bits in a final word
// BEHAVIOUR
//  Reset (rst_n=0 at a clock edge) sets:
//   - state LOAD_A, word_cnt 0.
//   - adder_in1 and adder_in2 = 0.
//   - op_valid 0, pad_err 0, s_ready 1 from the first cycle after reset.
//  State machine:
//   - LOAD_A: each accepted word (s_valid & s_ready) writes adder_in1[32k+31:32k]; k = word_cnt.
//     Word 5 writes only bits [162:160] from s_data[2:0].
//     word_cnt increments; after word 5, word_cnt returns to 0 and the state goes to LOAD_B.
//   - LOAD_B: same word mapping into adder_in2. After word 5, the state goes to HOLD.
//   - HOLD: op_valid=1, s_ready=0. Operands must not change.
//     On op_valid & op_ready, go to LOAD_A with op_valid=0 the next cycle.
//  Timing and handshake rules:
//   - op_valid rises the cycle after the 12th word is accepted.
//   - Minimum cycle time is 13 clocks per operand pair (12 words plus 1 handshake).
//   - s_ready = 1 in LOAD_A and LOAD_B, 0 in HOLD. It is registered/state-decoded only.
//   - There is no combinational path from s_valid, op_ready or abort to any output.
//   - Operand registers are not cleared between pairs. Each word overwrites only its own slice.
//  Pad rule:
//   - If a word-5 word is accepted with s_data[31:3] != 0, pad_err pulses for exactly 1 cycle.
//   - The pulse appears the cycle after acceptance.
//   - The pad bits are discarded; the load continues normally.
//  Abort:
//   - abort=1 at a clock edge in any state sets: state LOAD_A, word_cnt 0, op_valid 0.
//     adder_in1 and adder_in2 are cleared to 0.
//   - abort has priority over a same-cycle word handshake; that word is dropped.
//   - abort has priority over a same-cycle op_ready; that pair counts as not consumed.
//  Reset has priority over abort.
//  s_valid held high in HOLD has no effect. The word waits until s_ready returns.
//  Field arithmetic is not done here; the adder XORs the held operands combinationally.
// TESTING
//  1. Reset, then feed A = all-ones (words 0-4 = FFFFFFFF, word 5 = 00000007) and B = 1.
//     Required: op_valid rises 1 cycle after word 12.
//     Required: adder_in1 = 163'h7_FFFF...F, adder_in2 = 1, adder_out = 163'h7_FFFF...E.
//  2. A = 163'h2_AAAA...A, B = 163'h5_5555...5, back-to-back s_valid.
//     Required: adder_out = 163'h7_FFFF...F; s_ready = 0 during HOLD.
//  3. Hold op_ready = 0 for 20 cycles in HOLD.
//     Required: operands and op_valid stay stable, and no words are accepted.
//     Then op_ready = 1 for 1 cycle: op_valid = 0 next cycle and s_ready = 1.
//  4. Send a word-5 word of A equal to 32'hFFFFFFF8.
//     Required: pad_err pulses 1 cycle, adder_in1[162:160] = 0, and the load completes normally.
//  5. Assert abort after 3 words of B, in the same cycle as s_valid.
//     Required: that word is dropped, the state is LOAD_A with word_cnt 0, and both operands = 0.
//     A fresh 12-word load then completes correctly.
//  6. Drive rst_n = 0 for 1 cycle during HOLD.
//     Required: op_valid = 0, operands = 0, s_ready = 1 on the following cycle.

Source files
------------

// File: rtl/gf163_operand_loader.sv
// Word-serial loader assembling GF(2^163) operands A then B for the field adder.
// Latency: op_valid rises the cycle after the 12th accepted word; 13 clocks minimum per pair.
// Backpressure: s_ready drops while a complete pair is held; it returns after op_valid & op_ready.
module gf163_operand_loader #(
  parameter int FIELD_W = 163,
  parameter int BUS_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BUS_W-1:0]   s_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               abort,
  output logic [FIELD_W-1:0] adder_in1,
  output logic [FIELD_W-1:0] adder_in2,
  output logic               op_valid,
  input  logic               op_ready,
  output logic               pad_err
);

  localparam int NWORDS = (FIELD_W + BUS_W - 1) / BUS_W;
  localparam int CNT_W  = $clog2(NWORDS);
  localparam int LAST   = NWORDS - 1;
  // Number of meaningful bits carried by the final word; the rest are pad.
  localparam int PAD_LO = FIELD_W - LAST * BUS_W;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic               word_acc;
  logic               last_word;
  logic [FIELD_W-1:0] wr_mask;
  logic [FIELD_W-1:0] wr_dat;

  assign s_ready   = (state_q != HOLD);
  assign op_valid  = (state_q == HOLD);
  assign word_acc  = s_valid && s_ready;
  assign last_word = (word_cnt_q == CNT_W'(LAST));

  // Slice select: the final word's pad bits fall off the top of the mask.
  assign wr_mask = FIELD_W'({BUS_W{1'b1}}) << (int'(word_cnt_q) * BUS_W);
  assign wr_dat  = FIELD_W'({NWORDS{s_data}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= LOAD_A;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    if (abort) begin
      state_d    = LOAD_A;
      word_cnt_d = '0;
    end else begin
      case (state_q)
        LOAD_A, LOAD_B: begin
          if (word_acc) begin
            if (last_word) begin
              word_cnt_d = '0;
              state_d    = (state_q == LOAD_A) ? LOAD_B : HOLD;
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (op_ready) state_d = LOAD_A;
        end
        default: begin
          state_d    = LOAD_A;
          word_cnt_d = '0;
        end
      endcase
    end
  end

  // Operands are only overwritten slice by slice, never cleared between pairs.
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      adder_in1 <= '0;
      adder_in2 <= '0;
    end else if (word_acc) begin
      if (state_q == LOAD_A) adder_in1 <= (adder_in1 & ~wr_mask) | (wr_dat & wr_mask);
      if (state_q == LOAD_B) adder_in2 <= (adder_in2 & ~wr_mask) | (wr_dat & wr_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pad_err <= 1'b0;
    else        pad_err <= word_acc && !abort && last_word && (|s_data[BUS_W-1:PAD_LO]);
  end

endmodule

// File: tb/tb_gf163_operand_loader.sv
// Scoreboard bench for gf163_operand_loader: expected pairs queued at load, compared in HOLD.
module tb_gf163_operand_loader;

  localparam int FW = 163;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   s_data;
  logic          s_valid;
  logic          s_ready;
  logic          abort;
  logic [FW-1:0] adder_in1;
  logic [FW-1:0] adder_in2;
  logic          op_valid;
  logic          op_ready;
  logic          pad_err;

  int n_chk = 0;
  int n_err = 0;

  logic [FW-1:0] exp_a_q[$];
  logic [FW-1:0] exp_b_q[$];

  logic [FW-1:0] all1;
  logic [FW-1:0] pat_a;
  logic [FW-1:0] pat_b;

  gf163_operand_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .abort    (abort),
    .adder_in1(adder_in1),
    .adder_in2(adder_in2),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .pad_err  (pad_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase after acceptance.
  task automatic send_word(input logic [31:0] w, input logic exp_pad);
    int n;
    n = 0;
    s_data  = w;
    s_valid = 1'b1;
    while (!s_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_ready) chk("s_ready_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("pad_err", pad_err, exp_pad);
  endtask

  task automatic send_operand(input logic [FW-1:0] v, input logic [31:0] w5);
    for (int k = 0; k < 5; k++) send_word(v[k*32 +: 32], 1'b0);
    send_word(w5, |w5[31:3]);
  endtask

  task automatic load_pair(input logic [FW-1:0] a, input logic [FW-1:0] b, input logic [31:0] aw5);
    exp_a_q.push_back({aw5[2:0], a[159:0]});
    exp_b_q.push_back(b);
    send_operand(a, aw5);
    for (int k = 0; k < 5; k++) send_word(b[k*32 +: 32], 1'b0);
    chk("op_valid_before_last", op_valid, 1'b0);
    send_word({29'd0, b[162:160]}, 1'b0);
    chk("op_valid_after_last", op_valid, 1'b1);
  endtask

  task automatic check_hold();
    logic [FW-1:0] ea, eb;
    if (exp_a_q.size() == 0) begin
      chk("sb_underflow", 1'b1, 1'b0);
    end else begin
      ea = exp_a_q.pop_front();
      eb = exp_b_q.pop_front();
      chk("adder_in1", adder_in1, ea);
      chk("adder_in2", adder_in2, eb);
      chk("adder_out", adder_in1 ^ adder_in2, ea ^ eb);
      chk("hold_s_ready", s_ready, 1'b0);
    end
  endtask

  task automatic handshake();
    op_ready = 1'b1;
    @(posedge clk); #1;
    op_ready = 1'b0;
    chk("post_hs_op_valid", op_valid, 1'b0);
    chk("post_hs_s_ready", s_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [FW-1:0] held_a, held_b;
    all1     = '1;
    pat_a    = {3'b010, {80{2'b10}}};
    pat_b    = {3'b101, {80{2'b01}}};
    rst_n    = 1'b0;
    s_data   = '0;
    s_valid  = 1'b0;
    abort    = 1'b0;
    op_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_op_valid", op_valid, 1'b0);
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_pad_err", pad_err, 1'b0);
    chk("rst_in1", adder_in1, '0);
    chk("rst_in2", adder_in2, '0);

    // 1: all-ones plus one
    load_pair(all1, 163'd1, 32'h0000_0007);
    chk("t1_out_const", adder_in1 ^ adder_in2, all1 ^ 163'd1);
    check_hold();
    handshake();

    // 2: alternating patterns, back-to-back words
    load_pair(pat_a, pat_b, {29'd0, pat_a[162:160]});
    chk("t2_out_const", adder_in1 ^ adder_in2, all1);
    check_hold();

    // 3: stall in HOLD with a pending word
    held_a  = {3'b010, {80{2'b10}}};
    held_b  = {3'b101, {80{2'b01}}};
    s_data  = 32'hDEAD_BEEF;
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("t3_op_valid", op_valid, 1'b1);
      chk("t3_s_ready", s_ready, 1'b0);
      chk("t3_in1", adder_in1, held_a);
      chk("t3_in2", adder_in2, held_b);
    end
    s_valid = 1'b0;
    handshake();

    // 4: pad bits in A's final word
    load_pair({3'b000, {5{32'h1234_5678}}}, {3'b011, {5{32'h0F0F_F0F0}}}, 32'hFFFF_FFF8);
    chk("t4_in1_top", adder_in1[162:160], 3'b000);
    chk("t4_pad_idle", pad_err, 1'b0);
    check_hold();
    handshake();

    // 5: abort after 3 words of B, colliding with a word handshake
    send_operand(all1, 32'h0000_0007);
    for (int k = 0; k < 3; k++) send_word(32'hCAFE_0000 + k, 1'b0);
    s_data  = 32'h5A5A_5A5A;
    s_valid = 1'b1;
    abort   = 1'b1;
    @(posedge clk); #1;
    abort   = 1'b0;
    s_valid = 1'b0;
    chk("t5_op_valid", op_valid, 1'b0);
    chk("t5_s_ready", s_ready, 1'b1);
    chk("t5_in1", adder_in1, '0);
    chk("t5_in2", adder_in2, '0);
    load_pair(pat_b, pat_a, {29'd0, pat_b[162:160]});
    check_hold();

    // abort beats a same-cycle op_ready in HOLD
    abort    = 1'b1;
    op_ready = 1'b1;
    @(posedge clk); #1;
    abort    = 1'b0;
    op_ready = 1'b0;
    chk("abort_hs_op_valid", op_valid, 1'b0);
    chk("abort_hs_in1", adder_in1, '0);
    chk("abort_hs_in2", adder_in2, '0);

    // 6: reset during HOLD
    load_pair({3'b110, {5{32'h8000_0001}}}, {3'b001, {5{32'h7FFF_FFFE}}}, 32'h0000_0006);
    check_hold();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t6_op_valid", op_valid, 1'b0);
    chk("t6_s_ready", s_ready, 1'b1);
    chk("t6_in1", adder_in1, '0);
    chk("t6_in2", adder_in2, '0);

    chk("sb_empty", exp_a_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
